fetch_pc_gen: RTL
=================

# fetch_pc_gen

Front-end fetch-address generator and branch target buffer (BTB) that drives the F1 side of the dual-issue pipeline register block. Each cycle it presents a fetch-packet PC (slot 0 = PC, slot 1 = PC+4) together with per-slot taken predictions and targets. It advances the PC when the pipeline's frontend write-enable is high. It also accepts the execute-stage redirect and branch-resolution updates that close the prediction loop.

## Interface

Parameters:
- BTB_ENTRIES, 16: number of direct-mapped BTB entries; power of two, 4..256.
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.

Ports:
- clock_i  in  1  system clock; single clock domain.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- frontend_we_i  in  1  pipeline frontend write-enable; PC and BTB updates occur only when high.
- redirect_i  in  1  execute-stage wrong-branch indication.
- redirect_pc_i  in  32  correct next fetch PC when redirect_i.
- upd_valid_i  in  1  resolved control-flow instruction in execute.
- upd_pc_i  in  32  PC of the resolved instruction.
- upd_tgt_i  in  32  resolved taken target.
- upd_taken_i  in  1  resolved direction.
- f1_pc_o  out  32  current fetch-packet PC (slot 0).
- f1_pred_0_o / f1_pred_1_o  out  1 each  predicted taken, slot 0 / slot 1.
- f1_pred_tgt_0_o / f1_pred_tgt_1_o  out  32 each  predicted target per slot; 0 when not predicted.
- f1_stall_o  out  1  fetch not ready; high during BTB initialisation.

## Operation

- BTB entry fields: valid, tag = pc[31:IDX+2], target[31:0], 2-bit counter. IDX = log2(BTB_ENTRIES). Index = pc[IDX+1:2].
- Lookup: two combinational read ports, at f1_pc_o and at f1_pc_o+4.
  - Slot n predicts taken iff valid && tag match && counter[1].
- Slot-1 prediction is forced to 0 when slot 0 predicts taken.
- Next-PC priority when frontend_we_i = 1:
  - redirect_i → redirect_pc_i.
  - Otherwise pred_0 → tgt_0.
  - Otherwise pred_1 → tgt_1.
  - Otherwise f1_pc_o + 8, with 32-bit wrap-around.
- When frontend_we_i = 0, the PC holds. redirect_i is ignored while frontend_we_i = 0.
- BTB update, applied only when upd_valid_i && frontend_we_i && state RUN:
  - Hit, taken: counter saturating +1 (max 11); target := upd_tgt_i.
  - Hit, not taken: counter saturating −1 (min 00); target unchanged.
  - Miss, taken: allocate/overwrite the entry; valid := 1, tag, target, counter := 10.
  - Miss, not taken: no change.
- Same-cycle update and lookup to the same index: the lookup returns the pre-update contents.
- FSM, two states:
  - INIT: sweep counter clears valid for index 0..BTB_ENTRIES−1, one entry per cycle. f1_stall_o = 1, predictions forced 0, PC held at RESET_PC, updates and redirects ignored. After the last index, go to RUN.
  - RUN: normal operation; f1_stall_o = 0. Returns to INIT only on reset.
- Reset values: state INIT, sweep counter 0, f1_pc_o = RESET_PC, f1_stall_o = 1, all predictions and targets 0. BTB valid bits are undefined until the sweep completes; the sweep makes them 0.
- Reset asserted mid-operation: all of the above apply immediately and asynchronously, and the sweep restarts.

## Timing

- Prediction outputs are combinational from the f1_pc_o register and BTB contents; there are no extra cycles.
- A redirect sampled at edge k gives f1_pc_o = redirect_pc_i after edge k.
- A BTB update at edge k is visible to lookups from cycle k+1.
- INIT lasts exactly BTB_ENTRIES cycles after reset deassertion: f1_stall_o is high for the first BTB_ENTRIES rising edges and low after that.

## Structure

- Shared package / defs header:
  - Counter encodings: SNT=00, WNT=01, WT=10, ST=11.
  - BTB entry field widths.
  - Fetch-packet stride of 8.
- Sub-module `btb`: storage, two async read ports, one write port, and a clear-by-index port used by the INIT sweep.
- `fetch_pc_gen` contains the PC register, next-PC mux, FSM and counter-update logic.

## Test plan

- Reset release, BTB_ENTRIES=16, frontend_we_i=1 → f1_stall_o high 16 cycles, f1_pc_o=0 throughout, then 0x0, 0x8, 0x10 on successive cycles.
- Update pc=0x20, tgt=0x100, taken, with an empty BTB → entry allocated with counter 10. Next pass at f1_pc_o=0x20: f1_pred_0_o=1, tgt_0=0x100, following PC 0x100.
- Same entry, then pc=0x24 allocated taken → at f1_pc_o=0x20 slot 1 predicts only if slot 0 is not taken. Apply a not-taken update to 0x20 (counter 01) → slot 0=0, slot 1=1 with tgt_1, next PC = tgt_1.
- redirect_i with redirect_pc_i=0x400 and pred_0=1 in the same cycle → next PC 0x400. Repeat with frontend_we_i=0 → PC holds.
- Four taken updates on one entry, then one not-taken → counter saturates at 11 and the entry still predicts taken. A further not-taken update leaves counter 01 and the entry predicts not taken.
- Assert reset_n_i mid-run at PC 0x1234_5678 → f1_pc_o=RESET_PC immediately, f1_stall_o=1, prior BTB hits absent after the sweep.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Purpose: shared definitions for the fetch PC generator and its BTB:
//          counter encodings, FSM states, entry payload and stride constants.
package fetch_pc_gen_pkg;

    localparam int unsigned PC_W         = 32;
    localparam int unsigned CTR_W        = 2;
    localparam int unsigned SLOT_STRIDE  = 4;
    localparam int unsigned FETCH_STRIDE = 8;

    // 2-bit direction counter; the MSB is the taken prediction.
    typedef enum logic [CTR_W-1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    // Per-entry payload; tag and valid are held separately since the tag
    // width depends on the BTB size.
    typedef struct packed {
        logic [PC_W-1:0] tgt;
        ctr_e            ctr;
    } btb_data_t;

    function automatic ctr_e ctr_inc(input ctr_e c);
        return (c == CTR_ST) ? CTR_ST : ctr_e'(CTR_W'(c) + CTR_W'(1));
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_e'(CTR_W'(c) - CTR_W'(1));
    endfunction

    function automatic logic ctr_taken(input ctr_e c);
        return (c == CTR_WT) || (c == CTR_ST);
    endfunction

endpackage

// File: rtl/fetch_pc_gen_btb.sv
// Purpose: direct-mapped BTB storage.
// Ports:
//   clk                         clock
//   rd_idx_0/1, rd_*_0/1        async lookup ports for the two fetch slots
//   upd_idx, upd_*              async read port feeding the counter update
//   wr_en/wr_idx/wr_tag/wr_data write port; a write always sets valid
//   clr_en/clr_idx              clears one valid bit (initialisation sweep)
module fetch_pc_gen_btb
    import fetch_pc_gen_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned TAG_W   = 26
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx_0,
    output logic             rd_valid_0,
    output logic [TAG_W-1:0] rd_tag_0,
    output btb_data_t        rd_data_0,
    input  logic [IDX_W-1:0] rd_idx_1,
    output logic             rd_valid_1,
    output logic [TAG_W-1:0] rd_tag_1,
    output btb_data_t        rd_data_1,
    input  logic [IDX_W-1:0] upd_idx,
    output logic             upd_valid,
    output logic [TAG_W-1:0] upd_tag,
    output btb_data_t        upd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  btb_data_t        wr_data,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    btb_data_t        data_q  [ENTRIES];

    // Storage has no reset; valid bits are cleared by the sweep instead.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid_q[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            data_q[wr_idx]  <= wr_data;
        end
    end

    // Async reads return pre-write contents within the same cycle.
    always_comb begin
        rd_valid_0 = valid_q[rd_idx_0];
        rd_tag_0   = tag_q[rd_idx_0];
        rd_data_0  = data_q[rd_idx_0];
        rd_valid_1 = valid_q[rd_idx_1];
        rd_tag_1   = tag_q[rd_idx_1];
        rd_data_1  = data_q[rd_idx_1];
        upd_valid  = valid_q[upd_idx];
        upd_tag    = tag_q[upd_idx];
        upd_data   = data_q[upd_idx];
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Purpose: fetch-packet PC generator with BTB-based branch prediction.
// Ports:
//   clock_i, reset_n_i           clock, async active-low reset
//   frontend_we_i                advance PC / accept updates when high
//   redirect_i, redirect_pc_i    execute-stage redirect
//   upd_valid_i/pc/tgt/taken     branch resolution feeding the BTB
//   f1_pc_o                      slot-0 fetch PC (slot 1 = +4)
//   f1_pred_0/1_o, f1_pred_tgt_0/1_o  per-slot prediction and target
//   f1_stall_o                   high while the BTB is being initialised
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        frontend_we_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic [31:0] upd_tgt_i,
    input  logic        upd_taken_i,
    output logic [31:0] f1_pc_o,
    output logic        f1_pred_0_o,
    output logic        f1_pred_1_o,
    output logic [31:0] f1_pred_tgt_0_o,
    output logic [31:0] f1_pred_tgt_1_o,
    output logic        f1_stall_o
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = PC_W - 2 - IDX_W;

    fsm_e               state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc_1;

    logic               rd_valid_0, rd_valid_1, upd_valid;
    logic [TAG_W-1:0]   rd_tag_0, rd_tag_1, upd_tag;
    btb_data_t          rd_data_0, rd_data_1, upd_data;
    logic               wr_en, clr_en;
    logic [TAG_W-1:0]   wr_tag;
    btb_data_t          wr_data;
    logic               hit_0, hit_1, upd_hit;
    logic               unused_bits;

    assign pc_1    = pc_q + PC_W'(SLOT_STRIDE);
    assign f1_pc_o = pc_q;

    // Word-offset bits never address the BTB.
    assign unused_bits = ^{pc_q[1:0], pc_1[1:0], upd_pc_i[1:0]};

    fetch_pc_gen_btb #(
        .ENTRIES (BTB_ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk        (clock_i),
        .rd_idx_0   (pc_q[IDX_W+1:2]),
        .rd_valid_0 (rd_valid_0),
        .rd_tag_0   (rd_tag_0),
        .rd_data_0  (rd_data_0),
        .rd_idx_1   (pc_1[IDX_W+1:2]),
        .rd_valid_1 (rd_valid_1),
        .rd_tag_1   (rd_tag_1),
        .rd_data_1  (rd_data_1),
        .upd_idx    (upd_pc_i[IDX_W+1:2]),
        .upd_valid  (upd_valid),
        .upd_tag    (upd_tag),
        .upd_data   (upd_data),
        .wr_en      (wr_en),
        .wr_idx     (upd_pc_i[IDX_W+1:2]),
        .wr_tag     (wr_tag),
        .wr_data    (wr_data),
        .clr_en     (clr_en),
        .clr_idx    (sweep_q)
    );

    assign hit_0   = rd_valid_0 && (rd_tag_0 == pc_q[PC_W-1:IDX_W+2])
                     && ctr_taken(rd_data_0.ctr);
    assign hit_1   = rd_valid_1 && (rd_tag_1 == pc_1[PC_W-1:IDX_W+2])
                     && ctr_taken(rd_data_1.ctr);
    assign upd_hit = upd_valid && (upd_tag == upd_pc_i[PC_W-1:IDX_W+2]);

    // State, sweep counter and PC registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC, predictions and BTB write control.
    always_comb begin
        state_d         = state_q;
        sweep_d         = sweep_q;
        pc_d            = pc_q;
        clr_en          = 1'b0;
        wr_en           = 1'b0;
        wr_tag          = upd_pc_i[PC_W-1:IDX_W+2];
        wr_data         = '{tgt: upd_tgt_i, ctr: CTR_WT};
        f1_pred_0_o     = 1'b0;
        f1_pred_1_o     = 1'b0;
        f1_pred_tgt_0_o = '0;
        f1_pred_tgt_1_o = '0;
        f1_stall_o      = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                f1_stall_o = 1'b1;
                clr_en     = 1'b1;
                pc_d       = RESET_PC;
                sweep_d    = sweep_q + 1'b1;
                if (sweep_q == IDX_W'(BTB_ENTRIES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A taken slot 0 ends the packet, so slot 1 is suppressed.
                f1_pred_0_o = hit_0;
                f1_pred_1_o = hit_1 && !hit_0;
                if (f1_pred_0_o) f1_pred_tgt_0_o = rd_data_0.tgt;
                if (f1_pred_1_o) f1_pred_tgt_1_o = rd_data_1.tgt;

                if (frontend_we_i) begin
                    if (redirect_i)       pc_d = redirect_pc_i;
                    else if (f1_pred_0_o) pc_d = rd_data_0.tgt;
                    else if (f1_pred_1_o) pc_d = rd_data_1.tgt;
                    else                  pc_d = pc_q + PC_W'(FETCH_STRIDE);

                    // Miss+taken falls through to the default allocate payload.
                    if (upd_valid_i) begin
                        if (upd_hit) begin
                            wr_en = 1'b1;
                            if (upd_taken_i) begin
                                wr_data = '{tgt: upd_tgt_i, ctr: ctr_inc(upd_data.ctr)};
                            end else begin
                                wr_data = '{tgt: upd_data.tgt, ctr: ctr_dec(upd_data.ctr)};
                            end
                        end else if (upd_taken_i) begin
                            wr_en = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

endmodule
